// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg : BCD digit type, range constants and per-digit step helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   typedef struct packed {
      logic       carry;
      bcd_digit_t digit;
   } bcd_step_t;

   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

   function automatic bcd_step_t bcd_inc_digit(input bcd_digit_t d, input logic cin);
      bcd_step_t r;
      r.carry = 1'b0;
      r.digit = d;
      if (cin) begin
         if (d >= BCD_MAX) begin
            r.digit = BCD_ZERO;
            r.carry = 1'b1;
         end else begin
            r.digit = d + 4'd1;
         end
      end
      return r;
   endfunction

   function automatic bcd_step_t bcd_dec_digit(input bcd_digit_t d, input logic bin);
      bcd_step_t r;
      r.carry = 1'b0;
      r.digit = d;
      if (bin) begin
         if (d == BCD_ZERO) begin
            r.digit = BCD_MAX;
            r.carry = 1'b1;
         end else begin
            r.digit = d - 4'd1;
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce : synchronise, debounce and falling-edge detect a button
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module button_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic btn_n,
   output logic press_pulse
);

   localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_primed;
   logic [CW-1:0]          r_cnt;
   logic                   r_state;
   logic                   r_prev;
   logic                   r_armed;
   logic                   r_pulse;
   logic                   w_sync;
   logic                   w_valid;

   assign w_sync      = r_sync[SYNC_STAGES-1];
   assign w_valid     = r_primed[SYNC_STAGES-1];
   assign press_pulse = r_pulse;

   // Presses are ignored until a genuine released level has been seen after
   // reset, so a button held through reset never yields a phantom press.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_sync   <= '1;
         r_primed <= '0;
         r_cnt    <= '0;
         r_state  <= 1'b1;
         r_prev   <= 1'b1;
         r_armed  <= 1'b0;
         r_pulse  <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], btn_n};
         r_primed <= {r_primed[SYNC_STAGES-2:0], 1'b1};
         r_prev   <= r_state;
         r_armed  <= r_armed | (w_valid & w_sync & r_state);
         r_pulse  <= r_armed & r_prev & ~r_state;
         if (w_sync != r_state) begin
            if (r_cnt == C_LAST) begin
               r_state <= w_sync;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bcd_guess_counter.sv
// ----------------------------------------------------------------------------
// bcd_guess_counter : debounced Guess press steps an N-digit BCD up/down count
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_guess_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS          = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SATURATE        = 0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Guess_button,
   input  logic                  Clear,
   input  logic                  Load,
   input  logic [4*DIGITS-1:0]   Load_value,
   input  logic                  Down,
   input  logic [4*DIGITS-1:0]   Limit_value,
   output logic [4*DIGITS-1:0]   Count,
   output logic                  Guess_pulse,
   output logic                  Overflow,
   output logic                  Limit_reached
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0]      r_count;
   logic              r_ovf;
   logic              r_lim;
   logic              w_pulse;
   logic [DIGITS:0]   w_carry;
   logic [DIGITS:0]   w_borrow;
   logic [W-1:0]      w_inc;
   logic [W-1:0]      w_dec;
   logic [W-1:0]      w_load;
   logic [W-1:0]      w_count_nxt;
   logic              w_ovf_nxt;
   logic [DIGITS-1:0] w_lim_eq;

   button_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .Clock       (Clock),
      .Reset       (Reset),
      .btn_n       (Guess_button),
      .press_pulse (w_pulse)
   );

   assign w_carry[0]  = 1'b1;
   assign w_borrow[0] = 1'b1;

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_digit
         bcd_step_t w_up;
         bcd_step_t w_dn;
         assign w_up            = bcd_inc_digit(r_count[4*g +: 4], w_carry[g]);
         assign w_dn            = bcd_dec_digit(r_count[4*g +: 4], w_borrow[g]);
         assign w_inc[4*g +: 4] = w_up.digit;
         assign w_dec[4*g +: 4] = w_dn.digit;
         assign w_carry[g+1]    = w_up.carry;
         assign w_borrow[g+1]   = w_dn.carry;
         assign w_load[4*g +: 4] = bcd_clamp(Load_value[4*g +: 4]);
         // An out-of-range limit digit can never match a valid count digit.
         assign w_lim_eq[g] = (Limit_value[4*g +: 4] <= BCD_MAX) &&
                              (Limit_value[4*g +: 4] == w_count_nxt[4*g +: 4]);
      end
   endgenerate

   // Carry/borrow out of the top digit marks a step off the end of the range.
   always_comb begin
      w_count_nxt = r_count;
      w_ovf_nxt   = 1'b0;
      if (Clear) begin
         w_count_nxt = '0;
      end else if (Load) begin
         w_count_nxt = w_load;
      end else if (w_pulse) begin
         if (Down) begin
            w_ovf_nxt   = w_borrow[DIGITS];
            w_count_nxt = (w_borrow[DIGITS] && (SATURATE != 0)) ? r_count : w_dec;
         end else begin
            w_ovf_nxt   = w_carry[DIGITS];
            w_count_nxt = (w_carry[DIGITS] && (SATURATE != 0)) ? r_count : w_inc;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_lim   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_ovf   <= w_ovf_nxt;
         r_lim   <= &w_lim_eq;
      end
   end

   assign Count         = r_count;
   assign Guess_pulse   = w_pulse;
   assign Overflow      = r_ovf;
   assign Limit_reached = r_lim;

endmodule

`default_nettype wire

// File: tb/tb_bcd_guess_counter.sv
// ----------------------------------------------------------------------------
// tb_bcd_guess_counter : wrap and saturate instances against a decimal model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_guess_counter;

   localparam int S   = 2;
   localparam int DEB = 4;
   localparam int LAT = S + DEB + 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn;
   logic       Clear;
   logic       Load;
   logic       Down;
   logic [7:0] Load_value;
   logic [7:0] Limit_value;
   logic [7:0] cnt_w, cnt_s;
   logic       pls_w, pls_s, ovf_w, ovf_s, lim_w, lim_s;

   int vectors    = 0;
   int miscompares = 0;

   // Reference state: counts held as plain decimal integers
   int cnt0, cnt1;
   bit ovf0, ovf1, lim0, lim1;
   bit exp_pulse;
   int pend;

   always #5 clk = ~clk;

   bcd_guess_counter #(.DIGITS(2), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .SATURATE(0)) dut_w (
      .Clock(clk), .Reset(rst_n), .Guess_button(btn), .Clear(Clear), .Load(Load),
      .Load_value(Load_value), .Down(Down), .Limit_value(Limit_value),
      .Count(cnt_w), .Guess_pulse(pls_w), .Overflow(ovf_w), .Limit_reached(lim_w));

   bcd_guess_counter #(.DIGITS(2), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .SATURATE(1)) dut_s (
      .Clock(clk), .Reset(rst_n), .Guess_button(btn), .Clear(Clear), .Load(Load),
      .Load_value(Load_value), .Down(Down), .Limit_value(Limit_value),
      .Count(cnt_s), .Guess_pulse(pls_s), .Overflow(ovf_s), .Limit_reached(lim_s));

   function automatic int ld_val(input logic [7:0] v);
      int hi, lo;
      hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
      lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
      return hi * 10 + lo;
   endfunction

   function automatic logic [7:0] to_bcd(input int n);
      logic [3:0] h, l;
      h = 4'(n / 10);
      l = 4'(n % 10);
      return {h, l};
   endfunction

   function automatic bit lim_match(input int c, input logic [7:0] lv);
      if (lv[7:4] > 4'd9 || lv[3:0] > 4'd9) return 1'b0;
      return c == (int'(lv[7:4]) * 10 + int'(lv[3:0]));
   endfunction

   function automatic void mdl(input bit sat, input int ci, input bit cl, input bit ld,
                               input bit p, input bit dn, input logic [7:0] lv,
                               output int co, output bit o);
      co = ci;
      o  = 1'b0;
      if (cl)      co = 0;
      else if (ld) co = ld_val(lv);
      else if (p) begin
         if (dn) begin
            if (ci == 0) begin o = 1'b1; co = sat ? 0 : 99; end
            else co = ci - 1;
         end else begin
            if (ci == 99) begin o = 1'b1; co = sat ? 99 : 0; end
            else co = ci + 1;
         end
      end
   endfunction

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit cl, ld, dn, p;
      logic [7:0] lv, lm;
      cl = Clear; ld = Load; dn = Down; p = exp_pulse; lv = Load_value; lm = Limit_value;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         cnt0 = 0; cnt1 = 0; ovf0 = 0; ovf1 = 0; lim0 = 0; lim1 = 0;
         pend = 0; exp_pulse = 0;
      end else begin
         mdl(1'b0, cnt0, cl, ld, p, dn, lv, cnt0, ovf0);
         mdl(1'b1, cnt1, cl, ld, p, dn, lv, cnt1, ovf1);
         lim0 = lim_match(cnt0, lm);
         lim1 = lim_match(cnt1, lm);
         if (pend > 0) begin
            pend--;
            exp_pulse = (pend == 0);
         end else begin
            exp_pulse = 1'b0;
         end
      end
      chk1("pulse_wrap", pls_w, exp_pulse);
      chk1("pulse_sat", pls_s, exp_pulse);
      chk8("count_wrap", cnt_w, to_bcd(cnt0));
      chk8("count_sat", cnt_s, to_bcd(cnt1));
      chk1("ovf_wrap", ovf_w, ovf0);
      chk1("ovf_sat", ovf_s, ovf1);
      chk1("limit_wrap", lim_w, lim0);
      chk1("limit_sat", lim_s, lim1);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // mode: 0 plain, 1 Clear during the pulse, 2 Load during the pulse, 3 random Down
   task automatic press(input int lo, input int hi, input int mode);
      btn  = 1'b0;
      pend = LAT;
      for (int i = 0; i < lo; i++) begin
         if (mode == 3) Down = 1'($urandom_range(0, 1));
         tick();
         Clear = (mode == 1) && exp_pulse;
         Load  = (mode == 2) && exp_pulse;
         if (Load) Load_value = 8'($urandom);
      end
      Clear = 1'b0;
      Load  = 1'b0;
      btn   = 1'b1;
      ticks(hi);
   endtask

   task automatic do_load(input logic [7:0] v);
      Load_value = v;
      Load       = 1'b1;
      tick();
      Load = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; btn = 1'b1; Clear = 1'b0; Load = 1'b0; Down = 1'b0;
      Load_value = 8'h00; Limit_value = 8'h12;
      cnt0 = 0; cnt1 = 0; ovf0 = 0; ovf1 = 0; lim0 = 0; lim1 = 0; pend = 0; exp_pulse = 0;
      ticks(3);
      rst_n = 1'b1;
      ticks(5);

      // Twelve clean presses counting up
      for (int i = 0; i < 12; i++) press(20, 8, 0);

      // Fast toggling shorter than the debounce window
      for (int i = 0; i < 15; i++) begin
         btn = ~btn;
         ticks(2);
      end
      btn = 1'b1;
      ticks(10);

      // Range ends in wrap and saturate
      do_load(8'h99);
      press(10, 8, 0);
      Down = 1'b1;
      press(10, 8, 0);
      Clear = 1'b1; tick(); Clear = 1'b0;
      for (int i = 0; i < 3; i++) press(10, 8, 0);
      do_load(8'hA7);

      // Limit flag rise/fall and Clear colliding with a press
      Down = 1'b0;
      Limit_value = 8'h05;
      Clear = 1'b1; tick(); Clear = 1'b0;
      for (int i = 0; i < 6; i++) press(10, 8, 0);
      press(10, 8, 1);

      // Reset mid-debounce with the button held through reset release
      press(10, 8, 0);
      press(10, 8, 0);
      Limit_value = to_bcd(cnt0);
      tick();
      btn  = 1'b0;
      pend = LAT;
      ticks(4);
      #2 rst_n = 1'b0;
      #1;
      chk8("async_count_wrap", cnt_w, 8'h00);
      chk8("async_count_sat", cnt_s, 8'h00);
      chk1("async_pulse", pls_w, 1'b0);
      chk1("async_ovf", ovf_w, 1'b0);
      chk1("async_limit_wrap", lim_w, 1'b0);
      chk1("async_limit_sat", lim_s, 1'b0);
      cnt0 = 0; cnt1 = 0; pend = 0; exp_pulse = 0;
      ticks(3);
      rst_n = 1'b1;
      ticks(15);
      btn = 1'b1;
      ticks(12);
      press(10, 8, 0);

      // Randomised mix checked against the decimal model
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 6))
            0: begin
               Limit_value = 8'($urandom);
               press($urandom_range(LAT + 2, 16), $urandom_range(LAT + 1, 12), 0);
            end
            1: begin
               Limit_value = to_bcd((cnt0 + 1) % 100);
               press($urandom_range(LAT + 2, 16), $urandom_range(LAT + 1, 12), 3);
            end
            2: do_load(8'($urandom));
            3: begin
               for (int g = 0; g < 3; g++) begin
                  btn = 1'b0;
                  ticks($urandom_range(1, DEB - 1));
                  btn = 1'b1;
                  ticks($urandom_range(1, 3));
               end
               ticks(LAT + 2);
            end
            4: press($urandom_range(LAT + 2, 14), LAT + 2, 1);
            5: press($urandom_range(LAT + 2, 14), LAT + 2, 2);
            default: begin
               Down = 1'($urandom_range(0, 1));
               press($urandom_range(LAT + 2, 14), $urandom_range(LAT + 1, 10), 0);
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
